// File: rtl/aes_key_sched_ctrl.sv
// Sequencer and round-key store for the iterative AES-128 key-expansion datapath.
// Paces the datapath's registered g-function (GF/CAP per round) and captures all NR+1 round keys.
module aes_key_sched_ctrl #(
    parameter int NR = 10,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [127:0]  key_in,
    output logic [127:0]  ks_key_inx,
    output logic [3:0]    ks_count,
    output logic          ks_first_round,
    input  logic [127:0]  ks_key_out,
    output logic          busy,
    output logic          done,
    output logic          keys_valid,
    input  logic [AW-1:0] rd_addr,
    output logic [127:0]  rd_data
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_GF   = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    state;
    logic [AW-1:0] r;
    logic [127:0]  cur_key;
    logic [127:0]  key_buf [0:NR];
    logic          in_round;
    logic          last_round;

    assign in_round   = (state == S_GF) || (state == S_CAP);
    assign last_round = (r == AW'(NR));

    // cur_key is held across GF and CAP, so the datapath sees a stable key for the whole round.
    assign ks_key_inx     = cur_key;
    assign ks_first_round = (state == S_LOAD);
    assign ks_count       = in_round ? 4'(r - AW'(1)) : 4'd0;
    assign busy           = (state == S_LOAD) || in_round;

    // start is a single-cycle request with no ready: it is taken only in IDLE or DONE,
    // and a pulse arriving in any other state is dropped, never queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            r          <= '0;
            cur_key    <= '0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_LOAD;
                        cur_key    <= key_in;
                        keys_valid <= 1'b0;
                    end
                end
                S_LOAD: begin
                    state <= S_GF;
                    r     <= AW'(1);
                end
                S_GF: begin
                    state <= S_CAP;
                end
                S_CAP: begin
                    cur_key <= ks_key_out;
                    if (last_round) begin
                        state      <= S_DONE;
                        done       <= 1'b1;
                        keys_valid <= 1'b1;
                    end else begin
                        state <= S_GF;
                        r     <= r + AW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Buffer contents are not reset; keys_valid masks them from the read port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_LOAD) begin
                key_buf[0] <= ks_key_out;
            end else if (state == S_CAP) begin
                key_buf[r] <= ks_key_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (keys_valid && (rd_addr <= AW'(NR))) begin
            rd_data <= key_buf[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl with a behavioural Wh_key datapath (registered g, XOR expansion).
module tb_aes_key_sched_ctrl;

    localparam int NR = 10;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [127:0]  key_in;
    logic [127:0]  ks_key_inx;
    logic [3:0]    ks_count;
    logic          ks_first_round;
    logic [127:0]  ks_key_out;
    logic          busy;
    logic          done;
    logic          keys_valid;
    logic [AW-1:0] rd_addr;
    logic [127:0]  rd_data;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [127:0] fips_rk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic [2047:0] sbox_tbl = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    logic [79:0] rcon_tbl = 80'h01020408102040801b36;

    aes_key_sched_ctrl #(.NR(NR), .AW(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .key_in         (key_in),
        .ks_key_inx     (ks_key_inx),
        .ks_count       (ks_count),
        .ks_first_round (ks_first_round),
        .ks_key_out     (ks_key_out),
        .busy           (busy),
        .done           (done),
        .keys_valid     (keys_valid),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data)
    );

    always #5 clk = ~clk;

    // Datapath model: g(w3) registered every cycle, XOR word chain combinational.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return sbox_tbl[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        if (idx > 4'd9) return 8'h00;
        return rcon_tbl[79 - 8 * int'(idx) -: 8];
    endfunction

    function automatic logic [31:0] g_fn(input logic [31:0] w, input logic [3:0] idx);
        logic [31:0] rw;
        rw = {w[23:0], w[31:24]};
        return {sbox(rw[31:24]) ^ rcon(idx), sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])};
    endfunction

    logic [31:0] g_reg = '0;
    logic [31:0] w4, w5, w6, w7;

    always_ff @(posedge clk) g_reg <= g_fn(ks_key_inx[31:0], ks_count);

    always_comb begin
        w4 = ks_key_inx[127:96] ^ g_reg;
        w5 = ks_key_inx[95:64] ^ w4;
        w6 = ks_key_inx[63:32] ^ w5;
        w7 = ks_key_inx[31:0] ^ w6;
        ks_key_out = ks_first_round ? ks_key_inx : {w4, w5, w6, w7};
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start an expansion, check per-cycle controls for 24 cycles, optionally poke start mid-run.
    task automatic run_expand(input logic [127:0] key, input int poke_at, input logic [127:0] exp_rd1);
        int n_done;
        n_done = 0;
        @(negedge clk);
        start  = 1'b1;
        key_in = key;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            start = (k == poke_at);
            if (k == poke_at) key_in = '0;
            if (done) n_done++;
            if (k == 1) begin
                check("rd_at_accept", rd_data, exp_rd1);
                check("load_key_inx", ks_key_inx, key);
            end
            if (k == 2) check("rd_masked", rd_data, 128'd0);
            if (k <= 21) begin
                check($sformatf("first_c%0d", k), 128'(ks_first_round), 128'(k == 1));
                check($sformatf("count_c%0d", k), 128'(ks_count), (k == 1) ? 128'd0 : 128'((k - 2) / 2));
                check($sformatf("busy_c%0d", k), 128'(busy), 128'd1);
                check($sformatf("kv_c%0d", k), 128'(keys_valid), 128'd0);
            end else if (k == 22) begin
                check("done_c22", 128'(done), 128'd1);
                check("busy_c22", 128'(busy), 128'd0);
                check("kv_c22", 128'(keys_valid), 128'd1);
                check("count_c22", 128'(ks_count), 128'd0);
            end
        end
        check("done_pulses", 128'(n_done), 128'd1);
    endtask

    task automatic sweep_reverse(input string name);
        logic [127:0] exp_q[$];
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i > 0) check($sformatf("%s_rd%0d", name, i - 1), rd_data, exp_q.pop_front());
            if (i <= 10) begin
                rd_addr = AW'(10 - i);
                exp_q.push_back(fips_rk[10 - i]);
            end else if (i == 11) begin
                rd_addr = AW'(11);
                exp_q.push_back(128'd0);
            end
        end
    endtask

    task automatic read_key(input logic [AW-1:0] a, input logic [127:0] exp, input string tag);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        check(tag, rd_data, exp);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        key_in  = '0;
        rd_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_kv", 128'(keys_valid), 128'd0);
        check("rst_rd", rd_data, 128'd0);
        check("rst_inx", ks_key_inx, 128'd0);
        check("rst_count", 128'(ks_count), 128'd0);
        check("rst_first", 128'(ks_first_round), 128'd0);

        start  = 1'b1;
        key_in = FIPS_KEY;
        @(negedge clk);
        check("rst_over_start", 128'(busy), 128'd0);
        start = 1'b0;
        reset = 1'b0;

        run_expand(FIPS_KEY, 5, 128'd0);
        sweep_reverse("fips");

        rd_addr = '0;
        @(negedge clk);
        start  = 1'b1;
        key_in = FIPS_KEY;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("midrun_busy", 128'(busy), 128'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_kv", 128'(keys_valid), 128'd0);
        check("midrst_rd", rd_data, 128'd0);
        check("midrst_first", 128'(ks_first_round), 128'd0);
        check("midrst_count", 128'(ks_count), 128'd0);
        check("midrst_inx", ks_key_inx, 128'd0);

        run_expand(FIPS_KEY, 0, 128'd0);
        sweep_reverse("restart");

        run_expand(128'd0, 0, 128'd0);
        read_key(AW'(1), 128'h62636363626363636263636362636363, "zero_rk1");
        run_expand({128{1'b1}}, 0, 128'h62636363626363636263636362636363);
        read_key(AW'(1), 128'he8e9e9e917161616e8e9e9e917161616, "ones_rk1");
        read_key(AW'(0), {128{1'b1}}, "ones_rk0");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
